seg7_scan_driver: RTL and testbench

Next-generation multiplexed 7-segment display driver. It scans NUM_DIGITS hex digits onto a common segment bus and adds several features: per-frame PWM brightness, inter-digit dead time for ghosting suppression, optional leading-zero blanking, selectable output polarity, and a valid/ready load port whose updates take effect only on frame boundaries (tear-free). It sits between a register or status source and the board's LED digit block.

---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_tick_gen.sv | 33 +++
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

  // Bit positions of each segment on the 8-bit segment bus (a is the MSB, dp the LSB)
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Hex nibble to segment pattern, packed as {a,b,c,d,e,f,g}; a set bit means lit
  function automatic logic [6:0] hex_to_abcdefg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'b1111110;
      4'h1:    pattern = 7'b0110000;
      4'h2:    pattern = 7'b1101101;
      4'h3:    pattern = 7'b1111001;
      4'h4:    pattern = 7'b0110011;
      4'h5:    pattern = 7'b1011011;
      4'h6:    pattern = 7'b1011111;
      4'h7:    pattern = 7'b1110000;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1111011;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b0011111;
      4'hC:    pattern = 7'b1001110;
      4'hD:    pattern = 7'b0111101;
      4'hE:    pattern = 7'b1001111;
      default: pattern = 7'b1000111;
    endcase
    return pattern;
  endfunction

  // Clock divider so that one frame (num_digits slots of slot_ticks ticks) repeats at refresh_rate_hz
  function automatic int calc_div(input int clk_rate_hz, input int refresh_rate_hz,
                                  input int num_digits, input int slot_ticks);
    int quotient;
    quotient = clk_rate_hz / (refresh_rate_hz * num_digits * slot_ticks);
    return (quotient < 1) ? 1 : quotient;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Scan tick generator: a one-cycle tick every DIV clocks, or every clock when TICK_DIVIDE is 0.
module seg7_tick_gen #(
  parameter int CLK_RATE_HZ = 390625,
  parameter int DIV         = 1,
  parameter int TICK_DIVIDE = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  // A divider can never usefully exceed the clock rate itself; a zero divide request collapses to 1
  localparam int LIMITED = (DIV > CLK_RATE_HZ) ? CLK_RATE_HZ : DIV;
  localparam int EFF_DIV = (TICK_DIVIDE == 0 || LIMITED < 1) ? 1 : LIMITED;
  localparam int CW      = (EFF_DIV > 1) ? $clog2(EFF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(EFF_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-EFF_DIV counter; with EFF_DIV of 1 it sits at 0 and tick stays high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver with PWM brightness, dead time, leading-zero
// blanking, output polarity and a tear-free (frame-boundary) load port.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_RATE_HZ      = 390625,
  parameter int NUM_DIGITS       = 6,
  parameter int REFRESH_RATE_HZ  = 80,
  parameter int BRIGHTNESS_BITS  = 3,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0,
  parameter int TICK_DIVIDE      = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DIGITS*4-1:0]      data,
  input  logic [NUM_DIGITS-1:0]        digit_enable,
  input  logic [NUM_DIGITS-1:0]        decimal_point_enable,
  input  logic [BRIGHTNESS_BITS-1:0]   brightness,
  input  logic                         lz_blank,
  output logic                         frame_start,
  output logic [7:0]                   display_led_segments,
  output logic [NUM_DIGITS-1:0]        display_segment_enable
);

  localparam int S   = 1 << BRIGHTNESS_BITS;
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int DIV = calc_div(CLK_RATE_HZ, REFRESH_RATE_HZ, NUM_DIGITS, S);
  localparam logic [BRIGHTNESS_BITS-1:0] SC_LAST = BRIGHTNESS_BITS'(S - 1);
  localparam logic [DW-1:0]              D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [7:0]                 SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0]      EN_OFF  = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  logic                        tick;
  logic [BRIGHTNESS_BITS-1:0]  sc, sc_nxt;
  logic [DW-1:0]               d, d_nxt;
  logic                        boundary, transfer, apply;
  logic                        pending;

  logic [NUM_DIGITS*4-1:0]     sh_data, act_data, act_data_nxt;
  logic [NUM_DIGITS-1:0]       sh_en, act_en, act_en_nxt;
  logic [NUM_DIGITS-1:0]       sh_dp, act_dp, act_dp_nxt;
  logic [BRIGHTNESS_BITS-1:0]  sh_bright, act_bright, act_bright_nxt;
  logic                        sh_lz, act_lz, act_lz_nxt;

  logic [3:0]                  nibble;
  logic [6:0]                  pattern;
  logic                        tail_zero, suppress, lit;
  logic [7:0]                  seg_raw;
  logic [NUM_DIGITS-1:0]       en_raw;

  seg7_tick_gen #(
    .CLK_RATE_HZ (CLK_RATE_HZ),
    .DIV         (DIV),
    .TICK_DIVIDE (TICK_DIVIDE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Slot counter inside a digit, and digit index stepping when the slot counter wraps
  always_comb begin
    sc_nxt = sc;
    d_nxt  = d;
    if (tick) begin
      if (sc == SC_LAST) begin
        sc_nxt = '0;
        d_nxt  = (d == D_LAST) ? '0 : d + 1'b1;
      end else begin
        sc_nxt = sc + 1'b1;
      end
    end
  end

  assign boundary = tick && (sc == SC_LAST) && (d == D_LAST);
  assign transfer = in_valid && !pending;
  assign apply    = boundary && pending;
  assign in_ready = ~pending;

  // Shadow register captures a load; pending holds it until the next frame boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      sh_data   <= '0;
      sh_en     <= '0;
      sh_dp     <= '0;
      sh_bright <= '0;
      sh_lz     <= 1'b0;
    end else if (transfer) begin
      pending   <= 1'b1;
      sh_data   <= data;
      sh_en     <= digit_enable;
      sh_dp     <= decimal_point_enable;
      sh_bright <= brightness;
      sh_lz     <= lz_blank;
    end else if (apply) begin
      pending   <= 1'b0;
    end
  end

  // Active set seen by the scanner this cycle, including a copy landing on this boundary
  always_comb begin
    act_data_nxt   = act_data;
    act_en_nxt     = act_en;
    act_dp_nxt     = act_dp;
    act_bright_nxt = act_bright;
    act_lz_nxt     = act_lz;
    if (apply) begin
      act_data_nxt   = sh_data;
      act_en_nxt     = sh_en;
      act_dp_nxt     = sh_dp;
      act_bright_nxt = sh_bright;
      act_lz_nxt     = sh_lz;
    end
  end

  // Active register only changes on a frame boundary, so a frame is never torn
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_data   <= '0;
      act_en     <= '0;
      act_dp     <= '0;
      act_bright <= '0;
      act_lz     <= 1'b0;
    end else begin
      act_data   <= act_data_nxt;
      act_en     <= act_en_nxt;
      act_dp     <= act_dp_nxt;
      act_bright <= act_bright_nxt;
      act_lz     <= act_lz_nxt;
    end
  end

  // Decide whether the upcoming digit/slot is lit and build its raw segment and enable pattern
  always_comb begin
    nibble    = act_data_nxt[int'(d_nxt)*4 +: 4];
    pattern   = hex_to_abcdefg(nibble);
    tail_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(d_nxt) && act_data_nxt[i*4 +: 4] != 4'h0) begin
        tail_zero = 1'b0;
      end
    end
    suppress = act_lz_nxt && (d_nxt != '0) && tail_zero;
    lit      = act_en_nxt[d_nxt] && (sc_nxt != '0) && (sc_nxt <= act_bright_nxt) && !suppress;
    seg_raw  = '0;
    en_raw   = '0;
    if (lit) begin
      seg_raw[SEG_A]  = pattern[6];
      seg_raw[SEG_B]  = pattern[5];
      seg_raw[SEG_C]  = pattern[4];
      seg_raw[SEG_D]  = pattern[3];
      seg_raw[SEG_E]  = pattern[2];
      seg_raw[SEG_F]  = pattern[1];
      seg_raw[SEG_G]  = pattern[0];
      seg_raw[SEG_DP] = act_dp_nxt[d_nxt];
      en_raw[d_nxt]   = 1'b1;
    end
  end

  // Scan counters and registered, polarity-adjusted outputs; reset forces the display dark at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc                     <= '0;
      d                      <= '0;
      frame_start            <= 1'b0;
      display_led_segments   <= SEG_OFF;
      display_segment_enable <= EN_OFF;
    end else begin
      sc                     <= sc_nxt;
      d                      <= d_nxt;
      frame_start            <= boundary;
      display_led_segments   <= seg_raw ^ SEG_OFF;
      display_segment_enable <= en_raw ^ EN_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: 4 digits, 4-tick slots, tick every clock.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int BB = 2;

  // Segment patterns {a..g, dp=0} for each hex value
  localparam logic [7:0] HEX_TB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [ND*4-1:0] data;
  logic [ND-1:0] digit_enable;
  logic [ND-1:0] decimal_point_enable;
  logic [BB-1:0] brightness;
  logic          lz_blank;

  logic          in_ready, frame_start;
  logic [7:0]    seg;
  logic [ND-1:0] en;
  logic          in_ready_i, frame_start_i;
  logic [7:0]    seg_i;
  logic [ND-1:0] en_i;

  int compared   = 0;
  int mismatched = 0;
  logic [11:0] exp_q [$];

  seg7_scan_driver #(
    .CLK_RATE_HZ(390625), .NUM_DIGITS(ND), .REFRESH_RATE_HZ(80), .BRIGHTNESS_BITS(BB),
    .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0), .TICK_DIVIDE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .digit_enable(digit_enable), .decimal_point_enable(decimal_point_enable),
    .brightness(brightness), .lz_blank(lz_blank), .frame_start(frame_start),
    .display_led_segments(seg), .display_segment_enable(en)
  );

  seg7_scan_driver #(
    .CLK_RATE_HZ(390625), .NUM_DIGITS(ND), .REFRESH_RATE_HZ(80), .BRIGHTNESS_BITS(BB),
    .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1), .TICK_DIVIDE(0)
  ) dut_inv (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_i),
    .data(data), .digit_enable(digit_enable), .decimal_point_enable(decimal_point_enable),
    .brightness(brightness), .lz_blank(lz_blank), .frame_start(frame_start_i),
    .display_led_segments(seg_i), .display_segment_enable(en_i)
  );

  always #5 clk = ~clk;

  // Expected {segments, enables} for each of the 16 cycles of a frame showing the given load
  task automatic push_frame(input logic [15:0] dat, input logic [3:0] ena, input logic [3:0] dpe,
                            input logic [1:0] br, input logic lz);
    logic lit;
    logic [7:0] s;
    logic [3:0] e;
    for (int dg = 0; dg < ND; dg++) begin
      for (int sl = 0; sl < 4; sl++) begin
        lit = ena[dg] && (sl >= 1) && (sl <= int'(br)) &&
              !(lz && dg > 0 && ((dat >> (4*dg)) == 16'h0));
        s = lit ? (HEX_TB[dat[4*dg +: 4]] | {7'b0, dpe[dg]}) : 8'h00;
        e = lit ? (4'b0001 << dg) : 4'b0000;
        exp_q.push_back({s, e});
      end
    end
  endtask

  // Drive one load request for a single cycle once the port is ready
  task automatic load(input logic [15:0] dat, input logic [3:0] ena, input logic [3:0] dpe,
                      input logic [1:0] br, input logic lz);
    for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
    data = dat; digit_enable = ena; decimal_point_enable = dpe; brightness = br; lz_blank = lz;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Advance to the first frame_start cycle with nothing pending (the frame that shows the latest load)
  task automatic wait_applied(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1 && in_ready === 1'b1) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    int cyc;
    logic [11:0] exp;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (seg !== 8'h00) begin mismatched++; $display("FAIL reset_seg got=%h want=00", seg); end
    compared++; if (en !== 4'h0) begin mismatched++; $display("FAIL reset_en got=%h want=0", en); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    compared++; if (frame_start !== 1'b0) begin mismatched++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    compared++; if (seg_i !== 8'hFF) begin mismatched++; $display("FAIL reset_seg_inv got=%h want=FF", seg_i); end
    compared++; if (en_i !== 4'hF) begin mismatched++; $display("FAIL reset_en_inv got=%h want=F", en_i); end
    compared++; if ({in_ready_i, frame_start_i} !== 2'b10) begin mismatched++; $display("FAIL reset_hs_inv got=%b want=10", {in_ready_i, frame_start_i}); end
    reset_n = 1'b1;
    // Light the display, queue a second load, then reset in the middle of a lit slot
    load(16'h3456, 4'hF, 4'h0, 2'd3, 1'b0);
    wait_applied(ok, cyc);
    repeat (5) @(negedge clk);
    load(16'h789A, 4'hF, 4'hF, 2'd3, 1'b0);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL pending_before_reset ready got=%b want=0", in_ready); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if (seg !== 8'h00 || en !== 4'h0) begin mismatched++; $display("FAIL midreset_out got=%h/%h want=00/0", seg, en); end
    compared++; if (seg_i !== 8'hFF || en_i !== 4'hF) begin mismatched++; $display("FAIL midreset_out_inv got=%h/%h want=FF/F", seg_i, en_i); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midreset_ready got=%b want=1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_applied(ok, cyc);
    compared++; if (!ok || cyc != 16) begin mismatched++; $display("FAIL restart_first_frame cycles got=%0d want=16", cyc); end
    push_frame(16'h0, 4'h0, 4'h0, 2'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp = exp_q.pop_front();
      compared++;
      if ({seg, en} !== exp) begin mismatched++; $display("FAIL reset_dark k=%0d got=%h want=%h", k, {seg, en}, exp); end
    end
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    logic [11:0] exp;
    load(16'h12A0, 4'hF, 4'b0100, 2'd3, 1'b0);
    wait_applied(ok, cyc);
    compared++; if (!ok || cyc < 1 || cyc > 16) begin mismatched++; $display("FAIL load_latency cycles got=%0d want=1..16", cyc); end
    push_frame(16'h12A0, 4'hF, 4'b0100, 2'd3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp = exp_q.pop_front();
      compared++;
      if ({seg, en} !== exp) begin mismatched++; $display("FAIL basic k=%0d got=%h want=%h", k, {seg, en}, exp); end
      compared++;
      if ({seg_i, en_i} !== ~exp) begin mismatched++; $display("FAIL basic_inv k=%0d got=%h want=%h", k, {seg_i, en_i}, ~exp); end
    end
  endtask

  task automatic test_brightness;
    bit ok;
    int cyc;
    logic [11:0] exp;
    for (int b = 1; b >= 0; b--) begin
      load(16'hF00D, 4'hF, 4'b1001, 2'(b), 1'b0);
      wait_applied(ok, cyc);
      compared++; if (!ok) begin mismatched++; $display("FAIL bright_apply b=%0d got=timeout want=frame", b); end
      push_frame(16'hF00D, 4'hF, 4'b1001, 2'(b), 1'b0);
      for (int k = 0; k < 16; k++) begin
        if (k > 0) @(negedge clk);
        exp = exp_q.pop_front();
        compared++;
        if ({seg, en} !== exp) begin mismatched++; $display("FAIL bright b=%0d k=%0d got=%h want=%h", b, k, {seg, en}, exp); end
      end
    end
  endtask

  task automatic test_lz_blank;
    bit ok;
    int cyc;
    logic [11:0] exp;
    logic [15:0] pat [2];
    pat[0] = 16'h0050;
    pat[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      load(pat[p], 4'hF, 4'h0, 2'd3, 1'b1);
      wait_applied(ok, cyc);
      compared++; if (!ok) begin mismatched++; $display("FAIL lz_apply p=%0d got=timeout want=frame", p); end
      push_frame(pat[p], 4'hF, 4'h0, 2'd3, 1'b1);
      for (int k = 0; k < 16; k++) begin
        if (k > 0) @(negedge clk);
        exp = exp_q.pop_front();
        compared++;
        if ({seg, en} !== exp) begin mismatched++; $display("FAIL lz p=%0d k=%0d got=%h want=%h", p, k, {seg, en}, exp); end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int cyc;
    int stalls;
    logic [11:0] exp;
    wait_applied(ok, cyc);
    repeat (3) @(negedge clk);
    data = 16'hC0DE; digit_enable = 4'hF; decimal_point_enable = 4'b1010; brightness = 2'd2; lz_blank = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    data = 16'h0B07; digit_enable = 4'b1011; decimal_point_enable = 4'b0001; brightness = 2'd3; lz_blank = 1'b1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ready got=%b want=0", in_ready); end
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      stalls++;
    end
    compared++; if (frame_start !== 1'b1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL release_at_boundary fs/ready got=%b%b want=11 stalls=%0d", frame_start, in_ready, stalls); end
    push_frame(16'hC0DE, 4'hF, 4'b1010, 2'd2, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL b_accepted ready got=%b want=0", in_ready); end
        in_valid = 1'b0;
      end
      exp = exp_q.pop_front();
      compared++;
      if ({seg, en} !== exp) begin mismatched++; $display("FAIL frame_a k=%0d got=%h want=%h", k, {seg, en}, exp); end
    end
    wait_applied(ok, cyc);
    compared++; if (!ok || cyc != 1) begin mismatched++; $display("FAIL b_next_boundary cycles got=%0d want=1", cyc); end
    push_frame(16'h0B07, 4'b1011, 4'b0001, 2'd3, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp = exp_q.pop_front();
      compared++;
      if ({seg, en} !== exp) begin mismatched++; $display("FAIL frame_b k=%0d got=%h want=%h", k, {seg, en}, exp); end
    end
  endtask

  task automatic test_frame_strobe;
    bit ok;
    int cyc;
    int pulses;
    int pos;
    load(16'h8888, 4'hF, 4'hF, 2'd3, 1'b0);
    wait_applied(ok, cyc);
    compared++; if (!ok) begin mismatched++; $display("FAIL strobe_sync got=timeout want=frame"); end
    for (int w = 0; w < 3; w++) begin
      pulses = 0;
      pos = 0;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (frame_start === 1'b1) begin
          pulses++;
          pos = k;
          compared++;
          if (en !== 4'h0) begin mismatched++; $display("FAIL strobe_en w=%0d got=%h want=0", w, en); end
        end
      end
      compared++; if (pulses != 1) begin mismatched++; $display("FAIL strobe_count w=%0d got=%0d want=1", w, pulses); end
      compared++; if (pos != 16) begin mismatched++; $display("FAIL strobe_period w=%0d got=%0d want=16", w, pos); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    data = '0;
    digit_enable = '0;
    decimal_point_enable = '0;
    brightness = '0;
    lz_blank = 1'b0;
    $display("[TB] seg7_scan_driver bench start");
    test_reset;
    test_basic;
    test_brightness;
    test_lz_blank;
    test_back_to_back;
    test_frame_strobe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
